// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding types: instruction format codes, opcode constants,
// and an immediate range helper used by the legality checks.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } instr_format_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_SLLI   = 3'b001;
    localparam logic [2:0] F3_SRXI   = 3'b101;

    // True when every bit above msb equals bit msb, i.e. the value is the
    // sign extension of its low (msb+1) bits.
    function automatic logic fits_signed(input logic signed [31:0] v, input int msb);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 32; b++) begin
            if (b > msb && v[b] != v[msb]) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-tuple input handshake and instruction-memory write handshake.
// master = producer of fields / consumer of memory writes (bench or loader),
// slave  = the encoder.
interface instr_encoder_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            in_format;
    logic [6:0]            in_opcode;
    logic [2:0]            in_funct3;
    logic [6:0]            in_funct7;
    logic [4:0]            in_rd;
    logic [4:0]            in_rs1;
    logic [4:0]            in_rs2;
    logic [31:0]           in_imm;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport master (
        output in_valid, in_format, in_opcode, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, mem_ready,
        input  in_ready, mem_valid, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_format, in_opcode, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, mem_ready,
        output in_ready, mem_valid, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encoder_sync_fifo.sv
// Synchronous FIFO with extra-bit pointers. Pointers are reset; the storage
// array is not, since nothing reads it while the FIFO is empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    // Full/empty are taken from current state, so a push into a full FIFO is
    // refused even when a pop happens on the same edge.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Read/write pointer advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs field tuples into 32-bit words, drops
// tuples whose immediate cannot be represented, and streams the words into
// sequential instruction-memory addresses through a small FIFO.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instr_encoder_if.slave        bus,
    output logic                  enc_error,
    output logic [7:0]            err_count,
    output logic [ADDR_WIDTH-2:0] word_count
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-2:0] WC_STEP   = (ADDR_WIDTH-1)'(1);

    logic signed [31:0]    w_imm;
    logic [31:0]           w_word;
    logic                  w_legal;
    logic                  w_is_shift;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;
    logic [31:0]           w_head;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-2:0] r_word_count;
    logic [7:0]            r_err_count;
    logic                  r_enc_error;

    assign w_imm      = bus.in_imm;
    assign w_is_shift = (bus.in_opcode == OP_IMM) &&
                        ((bus.in_funct3 == F3_SLLI) || (bus.in_funct3 == F3_SRXI));

    // Field packing with immediate scrambling and representability check.
    always_comb begin
        w_word  = '0;
        w_legal = 1'b0;
        case (bus.in_format)
            FMT_R: begin
                w_word  = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
                w_legal = 1'b1;
            end
            FMT_I: begin
                if (w_is_shift) begin
                    w_word  = {bus.in_funct7, w_imm[4:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
                    w_legal = (w_imm[31:5] == '0);
                end else begin
                    w_word  = {w_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
                    w_legal = fits_signed(w_imm, 11);
                end
            end
            FMT_S: begin
                w_word  = {w_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, w_imm[4:0], bus.in_opcode};
                w_legal = fits_signed(w_imm, 11);
            end
            FMT_B: begin
                w_word  = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                           w_imm[4:1], w_imm[11], bus.in_opcode};
                w_legal = fits_signed(w_imm, 12) && !w_imm[0];
            end
            FMT_U: begin
                w_word  = {w_imm[31:12], bus.in_rd, bus.in_opcode};
                w_legal = (w_imm[11:0] == '0);
            end
            FMT_J: begin
                w_word  = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.in_rd, bus.in_opcode};
                w_legal = fits_signed(w_imm, 20) && !w_imm[0];
            end
            default: begin
                w_word  = '0;
                w_legal = 1'b0;
            end
        endcase
    end

    assign bus.in_ready = !w_full;
    assign w_accept     = bus.in_valid && !w_full;
    assign w_pop        = bus.mem_valid && bus.mem_ready;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept && w_legal),
        .i_data  (w_word),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Head is forced to zero while empty so the unreset storage never leaks out.
    assign bus.mem_valid = (w_count != '0);
    assign bus.mem_wdata = w_empty ? 32'h0 : w_head;
    assign bus.mem_addr  = r_addr;

    // Write address and written-word counter, both advancing per pop and wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= ADDR_BASE;
            r_word_count <= '0;
        end else if (w_pop) begin
            r_addr       <= r_addr + ADDR_STEP;
            r_word_count <= r_word_count + WC_STEP;
        end
    end

    // Rejected-tuple pulse and saturating reject counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enc_error <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_enc_error <= w_accept && !w_legal;
            if (w_accept && !w_legal && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign enc_error  = r_enc_error;
    assign err_count  = r_err_count;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: known RV32I encodings, illegal tuples,
// backpressure with a full FIFO, address wrap on a narrow instance, and
// asynchronous reset with words pending.
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        enc_error,   enc_error_w;
    logic [7:0]  err_count,   err_count_w;
    logic [10:0] word_count;
    logic [2:0]  word_count_w;
    int          n_checks;
    int          n_fail;

    instr_encoder_if #(.ADDR_WIDTH(12)) bus ();
    instr_encoder_if #(.ADDR_WIDTH(4))  bus_w ();

    instr_encoder #(.FIFO_DEPTH(4), .ADDR_WIDTH(12), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .enc_error  (enc_error),
        .err_count  (err_count),
        .word_count (word_count)
    );

    instr_encoder #(.FIFO_DEPTH(4), .ADDR_WIDTH(4), .BASE_ADDR(0)) dut_w (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_w.slave),
        .enc_error  (enc_error_w),
        .err_count  (err_count_w),
        .word_count (word_count_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Present one tuple and hold it until accepted; returns #1 after the accept edge.
    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        int waitc;
        waitc         = 0;
        bus.in_format = fmt;
        bus.in_opcode = op;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_imm    = imm;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.in_ready) check_val("send_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [31:0] addi_word(input int k);
        return (32'(k) << 20) | (32'(k) << 7) | 32'h13;
    endfunction

    logic [31:0] exp_w [5];
    int          idx;
    int          cyc;
    logic        acc;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        {bus.in_valid, bus.in_format, bus.in_opcode, bus.in_funct3, bus.in_funct7} = '0;
        {bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm} = '0;
        bus.mem_ready = 1'b1;
        {bus_w.in_valid, bus_w.in_format, bus_w.in_opcode, bus_w.in_funct3, bus_w.in_funct7} = '0;
        {bus_w.in_rd, bus_w.in_rs1, bus_w.in_rs2, bus_w.in_imm} = '0;
        bus_w.mem_ready = 1'b1;

        // Reset state
        #2;
        check_val("rst_mem_valid",  32'(bus.mem_valid), 32'd0);
        check_val("rst_mem_addr",   32'(bus.mem_addr),  32'd0);
        check_val("rst_mem_wdata",  bus.mem_wdata,      32'd0);
        check_val("rst_enc_error",  32'(enc_error),     32'd0);
        check_val("rst_err_count",  32'(err_count),     32'd0);
        check_val("rst_word_count", 32'(word_count),    32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Legal encodings, streamed with mem_ready=1
        send(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        check_val("add_word", bus.mem_wdata, 32'h002081B3);
        check_val("add_addr", 32'(bus.mem_addr), 32'd0);
        check_val("add_valid", 32'(bus.mem_valid), 32'd1);
        check_val("add_rd",  32'(bus.mem_wdata[11:7]),  32'd3);
        check_val("add_rs1", 32'(bus.mem_wdata[19:15]), 32'd1);
        check_val("add_rs2", 32'(bus.mem_wdata[24:20]), 32'd2);
        send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd2, 5'd1, 5'd0, 32'd5);
        check_val("addi_word", bus.mem_wdata, 32'h00508113);
        check_val("addi_addr", 32'(bus.mem_addr), 32'd4);
        send(3'd2, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd16);
        check_val("sw_word", bus.mem_wdata, 32'h0020A823);
        check_val("sw_addr", 32'(bus.mem_addr), 32'd8);
        send(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd20);
        check_val("beq_word", bus.mem_wdata, 32'hFE2086E3);
        check_val("beq_addr", 32'(bus.mem_addr), 32'd12);
        send(3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd32);
        check_val("jal_word", bus.mem_wdata, 32'h020000EF);
        send(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h12345000);
        check_val("lui_word", bus.mem_wdata, 32'h123450B7);
        check_val("lui_addr", 32'(bus.mem_addr), 32'd20);
        send(3'd1, 7'b0010011, 3'd5, 7'h20, 5'd1, 5'd2, 5'd0, 32'd3);
        check_val("srai_word", bus.mem_wdata, 32'h40315093);
        @(posedge clk); #1;
        check_val("drain_valid", 32'(bus.mem_valid), 32'd0);
        check_val("drain_addr",  32'(bus.mem_addr),  32'd28);
        check_val("drain_wc",    32'(word_count),    32'd7);

        // Illegal tuples: accepted but dropped
        send(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
        check_val("ill_b_err",   32'(enc_error),     32'd1);
        check_val("ill_b_valid", 32'(bus.mem_valid), 32'd0);
        send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'd4096);
        check_val("ill_i_err",   32'(enc_error),     32'd1);
        send(3'd4, 7'b0110111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h12345001);
        check_val("ill_u_err",   32'(enc_error),     32'd1);
        check_val("ill_u_valid", 32'(bus.mem_valid), 32'd0);
        @(posedge clk); #1;
        check_val("ill_err_end",  32'(enc_error),    32'd0);
        check_val("ill_err_count", 32'(err_count),   32'd3);
        check_val("ill_addr",     32'(bus.mem_addr), 32'd28);
        check_val("ill_wc",       32'(word_count),   32'd7);

        // Backpressure: fill FIFO with mem_ready low
        for (int k = 1; k <= 5; k++) exp_w[k-1] = addi_word(k);
        bus.mem_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'(k), 5'd0, 5'd0, 32'(k));
            check_val("bp_head_word", bus.mem_wdata, exp_w[0]);
            check_val("bp_head_addr", 32'(bus.mem_addr), 32'd28);
        end
        check_val("bp_full_ready", 32'(bus.in_ready), 32'd0);
        bus.in_format = 3'd1; bus.in_opcode = 7'b0010011; bus.in_funct3 = 3'd0;
        bus.in_funct7 = 7'd0; bus.in_rd = 5'd5; bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0;
        bus.in_imm = 32'd5;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check_val("bp_hold_ready", 32'(bus.in_ready),  32'd0);
            check_val("bp_hold_valid", 32'(bus.mem_valid), 32'd1);
            check_val("bp_hold_word",  bus.mem_wdata,      exp_w[0]);
            check_val("bp_hold_addr",  32'(bus.mem_addr),  32'd28);
        end
        bus.mem_ready = 1'b1;
        idx = 0;
        cyc = 0;
        while (idx < 5 && cyc < 20) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (bus.mem_valid && bus.mem_ready) begin
                check_val("bp_order_word", bus.mem_wdata, exp_w[idx]);
                check_val("bp_order_addr", 32'(bus.mem_addr), 32'(28 + 4 * idx));
                idx++;
            end
            @(posedge clk); #1;
            if (acc) bus.in_valid = 1'b0;
            cyc++;
        end
        check_val("bp_drain_done", 32'(idx), 32'd5);
        check_val("bp_end_valid", 32'(bus.mem_valid), 32'd0);
        check_val("bp_end_addr",  32'(bus.mem_addr),  32'd48);
        check_val("bp_end_wc",    32'(word_count),    32'd12);

        // Address wrap on the 4-bit instance
        for (int k = 0; k < 5; k++) begin
            bus_w.in_format = 3'd1; bus_w.in_opcode = 7'b0010011; bus_w.in_funct3 = 3'd0;
            bus_w.in_funct7 = 7'd0; bus_w.in_rd = 5'(k + 1); bus_w.in_rs1 = 5'd0;
            bus_w.in_rs2 = 5'd0; bus_w.in_imm = 32'(k + 1);
            bus_w.in_valid = 1'b1;
            @(posedge clk); #1;
            check_val("wrap_word", bus_w.mem_wdata, addi_word(k + 1));
            check_val("wrap_addr", 32'(bus_w.mem_addr), 32'((4 * k) % 16));
        end
        bus_w.in_valid = 1'b0;
        @(posedge clk); #1;
        check_val("wrap_wc",   32'(word_count_w),     32'd5);
        check_val("wrap_next", 32'(bus_w.mem_addr),   32'd4);

        // Reject counter saturates
        for (int k = 0; k < 260; k++) send(3'd6, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        check_val("sat_err_count", 32'(err_count), 32'd255);

        // Asynchronous reset with words pending
        bus.mem_ready = 1'b0;
        send(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        send(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd4, 5'd1, 5'd2, 32'd0);
        check_val("pre_rst_valid", 32'(bus.mem_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", 32'(bus.mem_valid), 32'd0);
        check_val("mid_rst_addr",  32'(bus.mem_addr),  32'd0);
        check_val("mid_rst_wdata", bus.mem_wdata,      32'd0);
        check_val("mid_rst_wc",    32'(word_count),    32'd0);
        check_val("mid_rst_err",   32'(err_count),     32'd0);
        check_val("mid_rst_wc_w",  32'(word_count_w),  32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("post_rst_ready", 32'(bus.in_ready),  32'd1);
        check_val("post_rst_valid", 32'(bus.mem_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Inverse of the decoder. Accepts RV32I instruction fields (format, opcode, funct3/funct7, register indices, immediate) over a valid/ready handshake and packs them into 32-bit instruction words, including immediate bit-scrambling. Words are buffered in a small FIFO and written to sequential addresses of instruction memory over a second valid/ready handshake. Used for the program loader and for self-checking benches that build instruction streams from fields.

Parameters:
FIFO_DEPTH, 4, encoded-word buffer entries (power of two, >=2)
ADDR_WIDTH, 12, byte-address width of instruction memory
BASE_ADDR, 0, first write address (word-aligned)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  field tuple valid
in_ready  out  1  encoder can accept
in_format  in  3  instr_format_t: R=0, I=1, S=2, B=3, U=4, J=5
in_opcode  in  7  opcode field
in_funct3  in  3  funct3
in_funct7  in  7  funct7 (R; also I-shift upper bits)
in_rd  in  5  destination register
in_rs1  in  5  source 1
in_rs2  in  5  source 2
in_imm  in  32  signed immediate (U: full value, low 12 bits zero)
mem_valid  out  1  write request
mem_ready  in  1  memory accepts
mem_addr  out  ADDR_WIDTH  byte address
mem_wdata  out  32  encoded word
enc_error  out  1  one-cycle pulse: tuple rejected
err_count  out  8  saturating count of rejected tuples
word_count  out  ADDR_WIDTH-1  words written since reset

Behaviour:
- Reset (async, rst_n=0): FIFO empty, mem_valid=0, mem_addr=BASE_ADDR, mem_wdata=0, enc_error=0, err_count=0, word_count=0, in_ready=1 after release.
- in_ready = FIFO not full; independent of in_valid and of a same-cycle pop.
- Accept on rising edge with in_valid&&in_ready. Encoding is combinational; a legal word is pushed the same edge.
- Packing: R {funct7,rs2,rs1,funct3,rd,op}; I {imm[11:0],rs1,funct3,rd,op}, except op=0010011 with funct3 001/101 gives {funct7,imm[4:0],rs1,funct3,rd,op}; S {imm[11:5],rs2,rs1,funct3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
- Legality: I/S imm must sign-extend from bit 11; B from bit 12 with imm[0]=0; J from bit 20 with imm[0]=0; U imm[11:0]=0; I-shift imm[4:0] only, imm[31:5] must be 0; format codes 6/7 illegal. Illegal tuple: accepted (handshake completes), not pushed, enc_error=1 for the next cycle, err_count+1 saturating at 255.
- Output: mem_valid = FIFO not empty; mem_wdata = FIFO head (registered storage). Latency: accept at edge N -> mem_valid=1 after edge N when FIFO was empty.
- Pop on mem_valid&&mem_ready: mem_addr += 4, wrapping modulo 2^ADDR_WIDTH; word_count += 1, wrapping.
- mem_valid/mem_wdata/mem_addr hold stable while mem_valid&&!mem_ready.
- Simultaneous push and pop: occupancy unchanged; full is evaluated before the pop.
- Reset mid-stream discards FIFO contents and restarts at BASE_ADDR.

Decomposition:
- instr_format_t enum and the opcode constants (OP_R=0110011, OP_IMM=0010011, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC) are added to enumTypes.svh, shared with the decoder.
- Sub-module sync_fifo (parameterised width/depth, full/empty, count) holds the buffer; packing and legality stay in instr_encoder.

Test Plan:
- R ADD op=0110011,f3=0,f7=0,rd=3,rs1=1,rs2=2 -> mem_wdata=0x002081B3 at mem_addr=0; chain through the decoder and check the fields round-trip.
- I ADDI rd=2,rs1=1,imm=5 -> 0x00508113 at addr 4; S SW rs1=1,rs2=2,f3=2,imm=16 -> 0x0020A823 at addr 8.
- B BEQ rs1=1,rs2=2,imm=-20 -> 0xFE2086E3; J JAL rd=1,imm=32 -> 0x020000EF; U LUI rd=1,imm=0x12345000 -> 0x123450B7.
- Illegal: B imm=3, I imm=4096, U imm=0x12345001 -> no push, three enc_error pulses, err_count=3, mem_addr unchanged.
- Backpressure: mem_ready=0, push 5 tuples with FIFO_DEPTH=4 -> in_ready drops after 4, outputs stable. Release mem_ready -> 4 words in order at consecutive addresses, then the 5th.
- Wrap and reset: ADDR_WIDTH=4, write 5 words -> 5th at addr 0. Assert rst_n low with FIFO non-empty -> mem_valid=0 and counters 0 immediately.
